// File: rtl/gpr_writeback_arbiter.sv
// Register-file write-port arbiter: ALU > mul/div > accelerator (with anti-starvation),
// plus a pending-destination scoreboard for long-latency hazard stalls.
module gpr_writeback_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        acc_valid,
    input  logic [4:0]  acc_rd,
    input  logic [31:0] acc_data,
    output logic        acc_ready,
    input  logic        issue_valid,
    input  logic        issue_long,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_add,
    input  logic [4:0]  rs2_add,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [4:0]  rd_add,
    output logic [31:0] data_write,
    output logic        write_en,
    output logic        orphan_err
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]  starve_q, starve_d;
    logic [31:0] pending_q, pending_d;
    logic        orphan_q, orphan_d;
    logic [4:0]  rd_add_q;
    logic [31:0] data_q;
    logic        write_en_q;
    logic        long_q;

    logic        starved;
    logic        accept;
    logic        long_accept;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    always_comb begin
        starved   = (starve_q >= LIMIT);
        md_ready  = ~alu_valid & md_valid & ~(starved & acc_valid);
        acc_ready = ~alu_valid & acc_valid & (~md_valid | starved);
        long_accept = md_ready | acc_ready;
        accept    = alu_valid | long_accept;

        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (md_ready) begin
            sel_rd   = md_rd;
            sel_data = md_data;
        end else if (acc_ready) begin
            sel_rd   = acc_rd;
            sel_data = acc_data;
        end
    end

    // Counter only moves on cycles the ALU leaves the port to the long-latency units.
    always_comb begin
        starve_d = starve_q;
        if (!alu_valid) begin
            if (!acc_valid || acc_ready)
                starve_d = 3'd0;
            else if (md_ready && starve_q < LIMIT)
                starve_d = starve_q + 3'd1;
        end
    end

    // Clear applied before set so a same-index re-issue keeps the bit pending.
    always_comb begin
        pending_d = pending_q;
        if (write_en_q && long_q)
            pending_d[rd_add_q] = 1'b0;
        if (issue_valid && issue_long && issue_rd != 5'd0)
            pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        orphan_d = orphan_q;
        if (long_accept && sel_rd != 5'd0 && !pending_q[sel_rd])
            orphan_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= 3'd0;
            pending_q  <= 32'd0;
            orphan_q   <= 1'b0;
            rd_add_q   <= 5'd0;
            data_q     <= 32'd0;
            write_en_q <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            orphan_q   <= orphan_d;
            write_en_q <= accept && (sel_rd != 5'd0);
            if (accept) begin
                rd_add_q <= sel_rd;
                data_q   <= sel_data;
                long_q   <= long_accept;
            end
        end
    end

    assign rs1_busy   = pending_q[rs1_add];
    assign rs2_busy   = pending_q[rs2_add];
    assign rd_add     = rd_add_q;
    assign data_write = data_q;
    assign write_en   = write_en_q;
    assign orphan_err = orphan_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench: stimulus pushes expected writes, a negedge monitor checks the write port.
module tb_gpr_writeback_arbiter;

    logic        clk, rst;
    logic        alu_valid, md_valid, acc_valid, issue_valid, issue_long;
    logic [4:0]  alu_rd, md_rd, acc_rd, issue_rd, rs1_add, rs2_add;
    logic [31:0] alu_data, md_data, acc_data;
    logic        md_ready, acc_ready, rs1_busy, rs2_busy, write_en, orphan_err;
    logic [4:0]  rd_add;
    logic [31:0] data_write;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    gpr_writeback_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .acc_valid(acc_valid), .acc_rd(acc_rd), .acc_data(acc_data), .acc_ready(acc_ready),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1_add(rs1_add), .rs2_add(rs2_add), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_add(rd_add), .data_write(data_write), .write_en(write_en), .orphan_err(orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst && write_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: rd=%0d data=0x%0h expected none", rd_add, data_write);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_rd", {27'd0, rd_add}, {27'd0, e.rd});
                check("wr_data", data_write, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; md_valid = 0; acc_valid = 0; issue_valid = 0; issue_long = 0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rd = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 0;
        idle();
        alu_rd = 0; alu_data = 0; md_rd = 0; md_data = 0; acc_rd = 0; acc_data = 0;
        issue_rd = 0; rs1_add = 0; rs2_add = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, write_en}, 32'd0);
        check("rst_rd", {27'd0, rd_add}, 32'd0);
        check("rst_data", data_write, 32'd0);
        check("rst_orphan", {31'd0, orphan_err}, 32'd0);
        tick();
        rst = 1;

        // ALU write to x5
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        tick();
        idle();

        // long op to x7, then md collides with ALU
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        tick();
        idle();
        rs1_add = 7;
        @(negedge clk);
        check("busy7_set", {31'd0, rs1_busy}, 32'd1);
        tick();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        md_valid = 1; md_rd = 7; md_data = 32'h77770000;
        push(3, 32'h33);
        @(negedge clk);
        check("md_blocked_by_alu", {31'd0, md_ready}, 32'd0);
        tick();
        alu_valid = 0;
        push(7, 32'h77770000);
        @(negedge clk);
        check("md_ready_free", {31'd0, md_ready}, 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("busy7_during_write", {31'd0, rs1_busy}, 32'd1);
        tick();
        @(negedge clk);
        check("busy7_after_write", {31'd0, rs1_busy}, 32'd0);
        tick();

        // starvation: issue x20..x26, then md and acc both valid
        for (int r = 20; r <= 26; r++) begin
            issue_valid = 1; issue_long = 1; issue_rd = 5'(r);
            tick();
        end
        idle();
        acc_valid = 1; acc_rd = 25; acc_data = 32'hACC0;
        md_valid = 1;
        for (int i = 0; i < 4; i++) begin
            md_rd = 5'(20 + i); md_data = 32'h100 + i;
            push(md_rd, md_data);
            @(negedge clk);
            check("starve_md_ready", {31'd0, md_ready}, 32'd1);
            check("starve_acc_ready", {31'd0, acc_ready}, 32'd0);
            tick();
        end
        md_rd = 24; md_data = 32'h104;
        push(25, 32'hACC0);
        @(negedge clk);
        check("starved_md_ready", {31'd0, md_ready}, 32'd0);
        check("starved_acc_ready", {31'd0, acc_ready}, 32'd1);
        tick();
        acc_rd = 26; acc_data = 32'hACC1;
        push(24, 32'h104);
        @(negedge clk);
        check("post_starve_md_ready", {31'd0, md_ready}, 32'd1);
        check("post_starve_acc_ready", {31'd0, acc_ready}, 32'd0);
        tick();
        idle();
        tick();
        rs2_add = 25;
        @(negedge clk);
        check("busy25_cleared", {31'd0, rs2_busy}, 32'd0);
        check("no_orphan_yet", {31'd0, orphan_err}, 32'd0);
        tick();

        // re-issue x9 in the cycle its pending write commits
        issue_valid = 1; issue_long = 1; issue_rd = 9;
        tick();
        idle();
        md_valid = 1; md_rd = 9; md_data = 32'h99;
        push(9, 32'h99);
        tick();
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 9;
        tick();
        idle();
        rs1_add = 9;
        @(negedge clk);
        check("busy9_set_wins", {31'd0, rs1_busy}, 32'd1);
        tick();

        // rd=0 result: no write, but address/data still update
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        tick();
        idle();
        @(negedge clk);
        check("x0_we", {31'd0, write_en}, 32'd0);
        check("x0_rd", {27'd0, rd_add}, 32'd0);
        check("x0_data", data_write, 32'h1234);
        tick();

        // orphan accelerator result to x12
        acc_valid = 1; acc_rd = 12; acc_data = 32'hC0FFEE;
        push(12, 32'hC0FFEE);
        @(negedge clk);
        check("orphan_acc_ready", {31'd0, acc_ready}, 32'd1);
        check("orphan_before", {31'd0, orphan_err}, 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("orphan_set", {31'd0, orphan_err}, 32'd1);
        tick();
        tick();
        @(negedge clk);
        check("orphan_sticky", {31'd0, orphan_err}, 32'd1);
        tick();

        // reset while a write is registered
        alu_valid = 1; alu_rd = 15; alu_data = 32'h55;
        tick();
        idle();
        check("pre_reset_we", {31'd0, write_en}, 32'd1);
        #1;
        rst = 0;
        #1;
        check("reset_drops_we", {31'd0, write_en}, 32'd0);
        check("reset_orphan", {31'd0, orphan_err}, 32'd0);
        check("reset_pending9", {31'd0, rs1_busy}, 32'd0);
        tick();
        rst = 1;
        tick();
        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_writeback_arbiter.md
# gpr_writeback_arbiter

Write-side controller for the 32x32 general-purpose register file: it merges results from the single-cycle ALU, the multi-cycle multiply/divide unit and the encryption accelerator into the register file's single write port. It also holds a pending-destination scoreboard so the issue stage can stall on long-latency hazards. It sits between the execute/accelerator result buses and the register file's `rd_add` / `data_write` / `write_en` inputs.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles the accelerator may lose arbitration to mul/div before it takes priority over mul/div.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid this cycle; never back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `md_valid`  in  1  mul/div result valid.
- `md_rd`  in  5  mul/div destination register.
- `md_data`  in  32  mul/div result.
- `md_ready`  out  1  mul/div result accepted this cycle (combinational).
- `acc_valid`  in  1  accelerator result valid.
- `acc_rd`  in  5  accelerator destination register.
- `acc_data`  in  32  accelerator result.
- `acc_ready`  out  1  accelerator result accepted this cycle (combinational).
- `issue_valid`  in  1  an instruction issues this cycle.
- `issue_long`  in  1  the issuing instruction targets mul/div or the accelerator.
- `issue_rd`  in  5  destination of the issuing instruction.
- `rs1_add`, `rs2_add`  in  5  source registers of the instruction in decode.
- `rs1_busy`, `rs2_busy`  out  1  source has a pending long-latency write (combinational from the scoreboard).
- `rd_add`  out  5  to register-file write address (registered).
- `data_write`  out  32  to register-file write data (registered).
- `write_en`  out  1  to register-file write enable (registered).
- `orphan_err`  out  1  sticky flag: a long-latency result arrived for a register that was not pending.

## Operation
- Arbitration per cycle, ALU first:
  - `alu_valid` always wins. `md_ready` = 0 and `acc_ready` = 0 in that cycle.
  - Otherwise mul/div beats the accelerator, unless the starvation counter has reached `STARVE_LIMIT`. In that case the accelerator beats mul/div.
  - Exactly one source is accepted per cycle at most. A source is accepted only when it is valid.
- Starvation counter (3 bits, saturating at `STARVE_LIMIT`):
  - Increments when `acc_valid` = 1 and mul/div is accepted.
  - Clears when the accelerator is accepted, or when `acc_valid` = 0.
  - Holds when the ALU wins.
- Accepted result is registered into `rd_add` / `data_write` with `write_en` = 1 on the next cycle.
  - Any result with rd = 0 is accepted but drives `write_en` = 0, so x0 is never written.
  - `rd_add` and `data_write` still update on an rd = 0 accept; `write_en` is the only qualifier.
- Scoreboard: 32-bit `pending` vector; bit 0 is hard-wired 0.
  - Set: `issue_valid` & `issue_long` & `issue_rd` != 0 sets `pending[issue_rd]`.
  - Clear: the edge at which a registered mul/div or accelerator write commits (`write_en` = 1 with a long-latency source tag) clears `pending[rd_add]`.
  - ALU writes never touch `pending`.
  - Simultaneous set and clear of the same index: set wins.
- `rsN_busy` = `pending[rsN_add]`.
  - Busy therefore remains high through the cycle in which the write is on the port.
  - The register-file value is valid from the following cycle.
- `orphan_err`: set when mul/div or the accelerator is accepted with rd != 0 and `pending[rd]` = 0. Cleared only by reset.

## Timing
- Reset (`rst` low, asynchronous) forces:
  - `write_en` = 0, `rd_add` = 0, `data_write` = 0.
  - `pending` = 0, starvation counter = 0, `orphan_err` = 0.
  - `md_ready` / `acc_ready` remain combinational functions of the inputs.
- Reset mid-operation discards any in-flight registered write; the write does not occur.
- Latency: accept in cycle N, then `write_en` high in cycle N+1, and the register file updates at the end of N+1.
- Back-to-back accepts produce back-to-back writes with no bubbles.
- Handshake: a source must hold valid, rd and data stable until its ready is sampled high. There is no skid buffering.

## Test plan
- Reset release, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF -> next cycle `write_en`=1, `rd_add`=5, `data_write`=0xDEADBEEF; all outputs 0 during reset.
- Issue long op to x7, then `md_valid`+`alu_valid` in the same cycle -> `md_ready`=0. The next cycle, ALU-free, `md_ready`=1 and x7 is written with the md data. `rs1_busy` (rs1=7) stays 1 through the write cycle and is 0 after it.
- `md_valid` and `acc_valid` held high continuously with no ALU traffic -> mul/div accepted 4 consecutive cycles, then the accelerator on cycle 5, then the counter clears and mul/div wins again.
- Issue long to x9 in the same cycle that a pending x9 write commits -> `pending[9]` remains 1.
- `acc_valid` with `acc_rd`=12 when nothing is pending -> write occurs, and `orphan_err` rises and stays 1 until reset.
- ALU result with rd=0, data 0x1234 -> `write_en` stays 0. Assert `rst` low while a write is registered -> `write_en` drops immediately.
